ym3438_timers: RTL and testbench
================================

# ym3438_timers

Timer A / Timer B block of the OPN2 core. Sits directly downstream of the bus interface. It consumes the interface's one-cycle address/data write strobes, the latched data bus and the bank bit, and decodes bank-0 registers 0x24–0x27. It produces the timer_a/timer_b status flags that the interface samples for status reads and IRQ. It also produces the channel-3 mode bits and the CSM key-on pulse consumed by the envelope stage.

## Interface
Parameters:
- TB_PRESCALE, 16, number of sample ticks per Timer B count; power of two, 2..256.

Ports:
- MCLK  in  1  master clock; all state updates on rising edge.
- reset  in  1  synchronous, active-high; driven from ~IC by the top level.
- tick  in  1  one-MCLK-cycle pulse, once per output sample.
- write_addr_en  in  1  one-cycle address-write strobe from the bus interface.
- write_data_en  in  1  one-cycle data-write strobe from the bus interface.
- data_bus  in  8  latched CPU data; valid whenever a strobe is high.
- bank  in  1  latched A1; must be 0 for this block to decode a register.
- timer_a  out  1  Timer A status flag.
- timer_b  out  1  Timer B status flag.
- timer_a_ovf  out  1  one-cycle pulse on every Timer A overflow, whether or not the flag is enabled.
- ch3_mode  out  2  reg 0x27 bits 7:6.
- csm_key_on  out  1  timer_a_ovf & (ch3_mode == 2'b10).

## Operation
- Address latch:
  - On write_addr_en, addr ← data_bus and addr_valid ← ~bank.
  - A data write is decoded only when addr_valid == 1 and bank == 0.
- Register writes, on write_data_en:
  - 0x24: ta[9:2] ← data.
  - 0x25: ta[1:0] ← data[1:0].
  - 0x26: tb ← data.
  - 0x27:
    - load_a ← d0, load_b ← d1.
    - en_a ← d2, en_b ← d3.
    - ch3_mode ← d7:6.
    - d4 = 1 clears timer_a; d5 = 1 clears timer_b. These two bits are strobes and are not stored.
  - Any other address: ignored.
- Timer A (10-bit cnt_a):
  - A 0→1 transition of load_a, caused by a write, sets cnt_a ← ta in that same cycle.
  - On tick with load_a = 1:
    - If cnt_a == 1023: cnt_a ← ta, pulse timer_a_ovf, and set timer_a if en_a.
    - Otherwise cnt_a ← cnt_a + 1.
  - When load_a = 0, cnt_a holds.
- Timer B (8-bit cnt_b, prescaler pre of log2(TB_PRESCALE) bits):
  - pre increments on every tick and free-runs from reset, independent of load_b.
  - The Timer B step occurs on a tick where pre == TB_PRESCALE−1.
  - A step behaves like Timer A, but with 255 as the overflow value, tb as the reload value and en_b as the flag enable.
  - A 0→1 transition of load_b sets cnt_b ← tb; pre is not reset.
- Flags:
  - A flag is set only by an enabled overflow.
  - A flag is cleared only by a reset-bit write or by reset.
  - Clearing en_x does not clear the flag.

## Timing
- Reset: all registers, counters, pre, addr and addr_valid go to 0. timer_a, timer_b, timer_a_ovf, ch3_mode and csm_key_on output 0 in the cycle after reset is sampled high.
- Reset has priority over everything, including a write strobe or tick in the same cycle.
- Register-write latency: 1 cycle. A write at edge N is visible in state after edge N.
- Flag latency: a tick at edge N that overflows gives timer_x = 1 and timer_a_ovf = 1 after edge N. The pulse lasts exactly one cycle.
- Simultaneous events:
  - Overflow and reset-bit write in the same cycle: the overflow wins, and the flag is 1 afterwards. No event is lost.
  - load 0→1 write and tick in the same cycle: the reload wins, so cnt ← ta (or tb). There is no increment that cycle.
  - Write to 0x24/0x25/0x26 and overflow in the same cycle: the reload uses the old ta/tb. The new value applies from the next reload.
  - write_addr_en and write_data_en together: not produced by the interface. The address is updated and the data write is ignored.
- Boundary values:
  - ta = 1023 overflows on every tick.
  - tb = 255 overflows on every Timer B step.
  - Counters never exceed their width; wrap is always via reload, never via natural rollover.

## Test plan
- Timer A reload and period: reset; write 0x24 = 0xFF, 0x25 = 0x03 (ta = 1023); write 0x27 = 0x05. The first tick gives timer_a_ovf and timer_a = 1 one cycle later. Every later tick also pulses timer_a_ovf.
- Timer A count length: ta = 1020, 0x27 = 0x05. Exactly 4 ticks elapse per overflow. Write 0x27 = 0x15 → timer_a = 0 next cycle, and it is set again at the next overflow.
- Timer B prescale: tb = 0xFE, 0x27 = 0x0A, TB_PRESCALE = 16. Overflows occur every 32 ticks, aligned to pre wrap. Ticks between steps leave cnt_b unchanged.
- Flag enable and CSM: ta = 1023, 0x27 = 0x81 (load_a, en_a = 0, ch3_mode = 2). On each tick, timer_a_ovf = 1 and csm_key_on = 1 while timer_a stays 0. With 0x27 = 0x41, csm_key_on stays 0.
- Bank and address gating: write address 0x27 with bank = 1, then data 0x05 → no change. Rewrite the same with bank = 0 → load_a = 1.
- Priorities: force an overflow in the same cycle as a 0x27 = 0x15 write → timer_a = 1 after. Assert reset together with tick at an overflow → all outputs 0 next cycle.

Source files
------------

// File: rtl/ym3438_timers.sv
// ym3438_timers: OPN2 Timer A / Timer B block (regs 0x24-0x27), status flags, CSM key-on.
// Revision 1.0
`default_nettype none

module ym3438_timers #(
  parameter int TB_PRESCALE = 16
) (
  input  logic       MCLK,
  input  logic       reset,
  input  logic       tick,
  input  logic       write_addr_en,
  input  logic       write_data_en,
  input  logic [7:0] data_bus,
  input  logic       bank,
  output logic       timer_a,
  output logic       timer_b,
  output logic       timer_a_ovf,
  output logic [1:0] ch3_mode,
  output logic       csm_key_on
);

  localparam int             PW       = (TB_PRESCALE > 1) ? $clog2(TB_PRESCALE) : 1;
  localparam logic [PW-1:0]  PRE_LAST = PW'(TB_PRESCALE - 1);

  logic [7:0]    addr_q, addr_d;
  logic          addr_valid_q, addr_valid_d;
  logic [9:0]    ta_q, ta_d;
  logic [7:0]    tb_q, tb_d;
  logic          load_a_q, load_a_d, load_b_q, load_b_d;
  logic          en_a_q, en_a_d, en_b_q, en_b_d;
  logic [1:0]    mode_q, mode_d;
  logic [9:0]    cnt_a_q, cnt_a_d;
  logic [7:0]    cnt_b_q, cnt_b_d;
  logic [PW-1:0] pre_q, pre_d;
  logic          timer_a_q, timer_a_d, timer_b_q, timer_b_d;
  logic          ovf_a_q, ovf_a_d;

  logic wr_en, wr_24, wr_25, wr_26, wr_27;
  logic step_b, ovf_b;

  always_comb begin
    // A simultaneous address strobe suppresses the data write.
    wr_en = write_data_en & ~write_addr_en & addr_valid_q & ~bank;
    wr_24 = wr_en & (addr_q == 8'h24);
    wr_25 = wr_en & (addr_q == 8'h25);
    wr_26 = wr_en & (addr_q == 8'h26);
    wr_27 = wr_en & (addr_q == 8'h27);

    addr_d       = addr_q;
    addr_valid_d = addr_valid_q;
    if (write_addr_en) begin
      addr_d       = data_bus;
      addr_valid_d = ~bank;
    end

    ta_d     = ta_q;
    tb_d     = tb_q;
    load_a_d = load_a_q;
    load_b_d = load_b_q;
    en_a_d   = en_a_q;
    en_b_d   = en_b_q;
    mode_d   = mode_q;
    if (wr_24) ta_d[9:2] = data_bus;
    if (wr_25) ta_d[1:0] = data_bus[1:0];
    if (wr_26) tb_d      = data_bus;
    if (wr_27) begin
      load_a_d = data_bus[0];
      load_b_d = data_bus[1];
      en_a_d   = data_bus[2];
      en_b_d   = data_bus[3];
      mode_d   = data_bus[7:6];
    end

    // Reloads use the old ta/tb, so a same-cycle period write applies next reload.
    ovf_a_d = tick & load_a_q & (cnt_a_q == 10'h3FF);
    cnt_a_d = cnt_a_q;
    if (wr_27 & data_bus[0] & ~load_a_q) cnt_a_d = ta_q;
    else if (tick & load_a_q)            cnt_a_d = ovf_a_d ? ta_q : cnt_a_q + 10'd1;

    pre_d   = tick ? pre_q + 1'b1 : pre_q;
    step_b  = tick & (pre_q == PRE_LAST);
    ovf_b   = step_b & load_b_q & (cnt_b_q == 8'hFF);
    cnt_b_d = cnt_b_q;
    if (wr_27 & data_bus[1] & ~load_b_q) cnt_b_d = tb_q;
    else if (step_b & load_b_q)          cnt_b_d = ovf_b ? tb_q : cnt_b_q + 8'd1;

    // An enabled overflow wins over a same-cycle flag-clear strobe.
    timer_a_d = (ovf_a_d & en_a_q) | (timer_a_q & ~(wr_27 & data_bus[4]));
    timer_b_d = (ovf_b & en_b_q)   | (timer_b_q & ~(wr_27 & data_bus[5]));
  end

  always_ff @(posedge MCLK) begin
    if (reset) begin
      addr_q       <= '0;
      addr_valid_q <= 1'b0;
      ta_q         <= '0;
      tb_q         <= '0;
      load_a_q     <= 1'b0;
      load_b_q     <= 1'b0;
      en_a_q       <= 1'b0;
      en_b_q       <= 1'b0;
      mode_q       <= '0;
      cnt_a_q      <= '0;
      cnt_b_q      <= '0;
      pre_q        <= '0;
      timer_a_q    <= 1'b0;
      timer_b_q    <= 1'b0;
      ovf_a_q      <= 1'b0;
    end else begin
      addr_q       <= addr_d;
      addr_valid_q <= addr_valid_d;
      ta_q         <= ta_d;
      tb_q         <= tb_d;
      load_a_q     <= load_a_d;
      load_b_q     <= load_b_d;
      en_a_q       <= en_a_d;
      en_b_q       <= en_b_d;
      mode_q       <= mode_d;
      cnt_a_q      <= cnt_a_d;
      cnt_b_q      <= cnt_b_d;
      pre_q        <= pre_d;
      timer_a_q    <= timer_a_d;
      timer_b_q    <= timer_b_d;
      ovf_a_q      <= ovf_a_d;
    end
  end

  assign timer_a     = timer_a_q;
  assign timer_b     = timer_b_q;
  assign timer_a_ovf = ovf_a_q;
  assign ch3_mode    = mode_q;
  assign csm_key_on  = ovf_a_q & (mode_q == 2'b10);

endmodule

`default_nettype wire

// File: tb/tb_ym3438_timers.sv
// tb_ym3438_timers: directed plus randomized check of ym3438_timers against a behavioural model.
// Revision 1.0
`default_nettype none

module tb_ym3438_timers;

  localparam int P = 16;

  logic       MCLK = 1'b0;
  logic       reset, tick, write_addr_en, write_data_en, bank;
  logic [7:0] data_bus;
  logic       timer_a, timer_b, timer_a_ovf, csm_key_on;
  logic [1:0] ch3_mode;

  int total = 0;
  int bad   = 0;

  // Architectural model state, kept as plain integers.
  int m_addr, m_av, m_ta, m_tb, m_la, m_lb, m_ea, m_eb, m_mode;
  int m_ca, m_cb, m_ticks, m_fa, m_fb, m_ovf;

  always #5 MCLK = ~MCLK;

  ym3438_timers #(.TB_PRESCALE(P)) dut (
    .MCLK(MCLK), .reset(reset), .tick(tick),
    .write_addr_en(write_addr_en), .write_data_en(write_data_en),
    .data_bus(data_bus), .bank(bank),
    .timer_a(timer_a), .timer_b(timer_b), .timer_a_ovf(timer_a_ovf),
    .ch3_mode(ch3_mode), .csm_key_on(csm_key_on)
  );

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Applies one clock of the behavioural rules using the inputs presented before the edge.
  task automatic model_update();
    int  na, nb, oa, ob, wr, w27, step;
    if (reset) begin
      m_addr = 0; m_av = 0; m_ta = 0; m_tb = 0; m_la = 0; m_lb = 0;
      m_ea = 0; m_eb = 0; m_mode = 0; m_ca = 0; m_cb = 0; m_ticks = 0;
      m_fa = 0; m_fb = 0; m_ovf = 0;
    end else begin
      wr  = (write_data_en && !write_addr_en && m_av == 1 && !bank) ? 1 : 0;
      w27 = (wr == 1 && m_addr == 'h27) ? 1 : 0;
      oa = 0; ob = 0;
      na = m_ca;
      if (w27 == 1 && data_bus[0] && m_la == 0) na = m_ta;
      else if (tick && m_la == 1) begin
        na = m_ca + 1;
        if (na == 1024) begin na = m_ta; oa = 1; end
      end
      step = (tick && (m_ticks % P) == P - 1) ? 1 : 0;
      if (tick) m_ticks++;
      nb = m_cb;
      if (w27 == 1 && data_bus[1] && m_lb == 0) nb = m_tb;
      else if (step == 1 && m_lb == 1) begin
        nb = m_cb + 1;
        if (nb == 256) begin nb = m_tb; ob = 1; end
      end
      if (oa == 1 && m_ea == 1) m_fa = 1;
      else if (w27 == 1 && data_bus[4]) m_fa = 0;
      if (ob == 1 && m_eb == 1) m_fb = 1;
      else if (w27 == 1 && data_bus[5]) m_fb = 0;
      if (wr == 1) begin
        case (m_addr)
          'h24: m_ta = (m_ta % 4) + int'(data_bus) * 4;
          'h25: m_ta = (m_ta / 4) * 4 + int'(data_bus) % 4;
          'h26: m_tb = int'(data_bus);
          'h27: begin
            m_la = data_bus[0]; m_lb = data_bus[1];
            m_ea = data_bus[2]; m_eb = data_bus[3];
            m_mode = int'(data_bus[7:6]);
          end
          default: ;
        endcase
      end
      if (write_addr_en) begin
        m_addr = int'(data_bus);
        m_av   = bank ? 0 : 1;
      end
      m_ca = na; m_cb = nb; m_ovf = oa;
    end
  endtask

  task automatic cyc(input logic r, input logic t, input logic a, input logic w,
                     input logic [7:0] dd, input logic b);
    reset = r; tick = t; write_addr_en = a; write_data_en = w; data_bus = dd; bank = b;
    @(posedge MCLK);
    model_update();
    #1;
    chk("timer_a",     {15'd0, timer_a},     16'(m_fa));
    chk("timer_b",     {15'd0, timer_b},     16'(m_fb));
    chk("timer_a_ovf", {15'd0, timer_a_ovf}, 16'(m_ovf));
    chk("ch3_mode",    {14'd0, ch3_mode},    16'(m_mode));
    chk("csm_key_on",  {15'd0, csm_key_on},  (m_ovf == 1 && m_mode == 2) ? 16'd1 : 16'd0);
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] dd);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, a, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, dd, 1'b0);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    end
  endtask

  initial begin
    logic       rt, ra, rw, rb;
    logic [7:0] rd;
    int         sel;

    cyc(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 1'b0, 8'h27, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);

    // Timer A with ta = 1023 overflows on every tick.
    wr(8'h24, 8'hFF); wr(8'h25, 8'h03); wr(8'h27, 8'h05);
    ticks(4);

    // ta = 1020: four ticks per overflow, then flag clear and re-set.
    wr(8'h25, 8'h00); wr(8'h27, 8'h04); wr(8'h27, 8'h05);
    ticks(10);
    wr(8'h27, 8'h15);
    ticks(5);

    // Timer B prescaled steps.
    wr(8'h26, 8'hFE); wr(8'h27, 8'h0A);
    ticks(70);

    // Disabled flag with CSM mode, then a non-CSM mode.
    wr(8'h27, 8'h00); wr(8'h25, 8'h03); wr(8'h27, 8'h81);
    ticks(3);
    wr(8'h27, 8'h41);
    ticks(3);

    // Bank gating: bank-1 address leaves the data write undecoded.
    wr(8'h27, 8'h00);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'h27, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 8'h05, 1'b0);
    ticks(2);
    wr(8'h27, 8'h05);
    ticks(2);

    // Overflow coincident with a flag-clear write, then reset with a tick.
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 8'h27, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 1'b1, 8'h15, 1'b0);
    chk("prio_flag", {15'd0, timer_a}, 16'd1);
    cyc(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
    cyc(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
    chk("rst_ovf", {15'd0, timer_a_ovf}, 16'd0);

    // Randomized traffic biased toward short timer periods.
    for (int n = 0; n < 3000; n++) begin
      sel = $urandom_range(0, 99);
      rt = ($urandom_range(0, 1) == 1);
      ra = 1'b0; rw = 1'b0; rb = ($urandom_range(0, 7) == 0);
      rd = 8'($urandom);
      if (sel < 1) begin
        cyc(1'b1, rt, 1'b0, 1'b0, rd, 1'b0);
        continue;
      end else if (sel < 12) begin
        ra = 1'b1;
        rd = ($urandom_range(0, 9) == 0) ? rd : 8'(8'h24 + $urandom_range(0, 3));
      end else if (sel < 24) begin
        rw = 1'b1;
        if (m_addr == 'h24) rd = 8'($urandom_range(8'hF0, 8'hFF));
        if (m_addr == 'h26) rd = 8'($urandom_range(8'hE0, 8'hFF));
      end else if (sel < 26) begin
        ra = 1'b1; rw = 1'b1;
      end
      cyc(1'b0, rt, ra, rw, rd, rb);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
